// File: rtl/dpram_param.sv
`default_nettype none
// ============================================================================
// Module      : dpram_param
// Description : Single-clock true dual-port RAM with a power-on/on-demand
//               clear engine, selectable read-during-write and optional
//               output register.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_param #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DEPTH    = 256,
   parameter int unsigned       RDW_MODE = 0,
   parameter int unsigned       OUT_REG  = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              ena,
   input  logic              enb,
   input  logic              wea,
   input  logic              web,
   input  logic [ADDR_W-1:0] addra,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] dina,
   input  logic [DATA_W-1:0] dinb,
   output logic [DATA_W-1:0] douta,
   output logic [DATA_W-1:0] doutb,
   output logic              ready,
   output logic              collision,
   output logic              addr_err
);

   localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              live;
   logic              in_rng_a, in_rng_b;
   logic              wr_a, wr_b, same_addr;
   logic [IDX_W-1:0]  idx_a, idx_b;
   logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
   logic              collision_q, collision_d;
   logic              addr_err_q, addr_err_d;

   // A clear request takes priority over any access presented with it.
   assign live      = (state_q == S_RUN) && !clr;
   assign idx_a     = addra[IDX_W-1:0];
   assign idx_b     = addrb[IDX_W-1:0];
   assign same_addr = (addra == addrb);
   assign wr_a      = live && ena && wea && in_rng_a;
   assign wr_b      = live && enb && web && in_rng_b;

   generate
      if (DEPTH == (1 << ADDR_W)) begin : g_full_depth
         assign in_rng_a = 1'b1;
         assign in_rng_b = 1'b1;
      end else begin : g_part_depth
         localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
         assign in_rng_a = ({1'b0, addra} < DEPTH_C);
         assign in_rng_b = ({1'b0, addrb} < DEPTH_C);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (clr) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      rd_a_d      = rd_a_q;
      rd_b_d      = rd_b_q;
      collision_d = wr_a && wr_b && same_addr;
      addr_err_d  = live && ((ena && !in_rng_a) || (enb && !in_rng_b));
      if (!live) begin
         rd_a_d = '0;
         rd_b_d = '0;
      end else begin
         if (ena) begin
            if (!in_rng_a)                rd_a_d = '0;
            else if (wea && RDW_MODE == 1) rd_a_d = dina;
            else                          rd_a_d = mem[idx_a];
         end
         // On a same-address double write port A's data is the one stored.
         if (enb) begin
            if (!in_rng_b)                rd_b_d = '0;
            else if (web && RDW_MODE == 1) rd_b_d = (wr_a && same_addr) ? dina : dinb;
            else                          rd_b_d = mem[idx_b];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CLEAR;
         cnt_q       <= '0;
         rd_a_q      <= '0;
         rd_b_q      <= '0;
         collision_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_a_q      <= rd_a_d;
         rd_b_q      <= rd_b_d;
         collision_q <= collision_d;
         addr_err_q  <= addr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         mem[cnt_q] <= INIT_VAL;
      end else begin
         if (wr_b && !(wr_a && same_addr)) mem[idx_b] <= dinb;
         if (wr_a)                         mem[idx_a] <= dina;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

         always_comb begin
            out_a_d = live ? rd_a_q : '0;
            out_b_d = live ? rd_b_q : '0;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_a_q <= '0;
               out_b_q <= '0;
            end else begin
               out_a_q <= out_a_d;
               out_b_q <= out_b_d;
            end
         end

         assign douta = out_a_q;
         assign doutb = out_b_q;
      end else begin : g_no_out_reg
         assign douta = rd_a_q;
         assign doutb = rd_b_q;
      end
   endgenerate

   assign ready     = (state_q == S_RUN);
   assign collision = collision_q;
   assign addr_err  = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_param
// Description : Self-checking bench for dpram_param; two builds share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_param;

   logic clk, rst_n, clr, ena, enb, wea, web;
   logic [7:0] addra, addrb, dina, dinb;
   logic [1:0][7:0] da, db;
   logic [1:0] rdy, col, err;

   int checks = 0;
   int errors = 0;

   // Build 0: default geometry, read-first, no output register.
   dpram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0), .OUT_REG(0),
                 .INIT_VAL(8'h5a)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .douta(da[0]), .doutb(db[0]), .ready(rdy[0]), .collision(col[0]), .addr_err(err[0]));

   // Build 1: partial depth, write-first, output register.
   dpram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .OUT_REG(1),
                 .INIT_VAL(8'h5a)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .douta(da[1]), .doutb(db[1]), .ready(rdy[1]), .collision(col[1]), .addr_err(err[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int         m_depth [2] = '{256, 200};
   int         m_rdw   [2] = '{0, 1};
   int         m_oreg  [2] = '{0, 1};
   int         m_left  [2];              // clear edges still to go; 0 = usable
   logic [7:0] m_mem   [2][256];
   logic [7:0] m_ra [2], m_rb [2], m_oa [2], m_ob [2];
   logic       m_col [2], m_err [2];

   task automatic m_reset(input int k);
      m_left[k] = m_depth[k];
      m_ra[k] = 8'h00; m_rb[k] = 8'h00; m_oa[k] = 8'h00; m_ob[k] = 8'h00;
      m_col[k] = 1'b0; m_err[k] = 1'b0;
   endtask

   task automatic m_step(input int k);
      bit ina, inb, wa, wb;
      if (!rst_n) begin
         m_reset(k);
      end else if (m_left[k] > 0) begin
         m_mem[k][m_depth[k] - m_left[k]] = 8'h5a;
         m_left[k]--;
         m_ra[k] = 8'h00; m_rb[k] = 8'h00; m_oa[k] = 8'h00; m_ob[k] = 8'h00;
         m_col[k] = 1'b0; m_err[k] = 1'b0;
      end else if (clr) begin
         m_reset(k);
      end else begin
         ina = int'(addra) < m_depth[k];
         inb = int'(addrb) < m_depth[k];
         wa  = ena && wea && ina;
         wb  = enb && web && inb;
         m_oa[k] = m_ra[k];
         m_ob[k] = m_rb[k];
         if (ena) m_ra[k] = !ina ? 8'h00 : (wea && m_rdw[k] == 1) ? dina : m_mem[k][addra];
         if (enb) m_rb[k] = !inb ? 8'h00 :
                            (web && m_rdw[k] == 1) ? ((wa && addra == addrb) ? dina : dinb) :
                            m_mem[k][addrb];
         m_col[k] = wa && wb && (addra == addrb);
         m_err[k] = (ena && !ina) || (enb && !inb);
         if (wb) m_mem[k][addrb] = dinb;
         if (wa) m_mem[k][addra] = dina;
      end
   endtask

   always @(posedge clk) begin
      m_step(0);
      m_step(1);
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("m%0d_douta", k), int'(da[k]), int'(m_oreg[k] != 0 ? m_oa[k] : m_ra[k]));
         chk($sformatf("m%0d_doutb", k), int'(db[k]), int'(m_oreg[k] != 0 ? m_ob[k] : m_rb[k]));
         chk($sformatf("m%0d_ready", k), int'(rdy[k]), int'(m_left[k] == 0));
         chk($sformatf("m%0d_coll", k), int'(col[k]), int'(m_col[k]));
         chk($sformatf("m%0d_aerr", k), int'(err[k]), int'(m_err[k]));
      end
   end

   // ---------------- directed vectors (checked against build 0) ----------------
   typedef struct {
      logic       ena, wea;
      logic [7:0] addra, dina;
      logic       enb, web;
      logic [7:0] addrb, dinb, exp_a, exp_b;
      logic       exp_col;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic ea, input logic wa_, input logic [7:0] aa,
                               input logic [7:0] ia, input logic eb, input logic wb_,
                               input logic [7:0] ab, input logic [7:0] ib,
                               input logic [7:0] xa, input logic [7:0] xb, input logic xc);
      vec_t v;
      v.ena = ea; v.wea = wa_; v.addra = aa; v.dina = ia;
      v.enb = eb; v.web = wb_; v.addrb = ab; v.dinb = ib;
      v.exp_a = xa; v.exp_b = xb; v.exp_col = xc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      ena = v.ena; wea = v.wea; addra = v.addra; dina = v.dina;
      enb = v.enb; web = v.web; addrb = v.addrb; dinb = v.dinb;
   endtask

   task automatic idle();
      ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
   endtask

   // Counts falling edges until build 0 reports ready; clr is a one-edge pulse.
   task automatic count_ready(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         clr = 1'b0;
      end while (!rdy[0] && n < 400);
   endtask

   task automatic reset_pulse();
      int n;
      @(negedge clk);
      #2 rst_n = 1'b0;
      m_reset(0);
      m_reset(1);
      #1;
      chk("rst_douta0", int'(da[0]), 0);
      chk("rst_douta1", int'(da[1]), 0);
      chk("rst_ready0", int'(rdy[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      count_ready(n);
      chk("rst_clear_len", n, 256);
   endtask

   initial begin
      int n;
      tbl[0]  = mk(1, 1, 8'h00, 8'ha0, 1, 1, 8'h01, 8'hb0, 8'h5a, 8'h5a, 0);
      tbl[1]  = mk(1, 1, 8'h02, 8'hc0, 1, 1, 8'h03, 8'hd0, 8'h5a, 8'h5a, 0);
      tbl[2]  = mk(1, 1, 8'h04, 8'he0, 1, 1, 8'h05, 8'hf0, 8'h5a, 8'h5a, 0);
      tbl[3]  = mk(1, 1, 8'h06, 8'h0a, 1, 1, 8'h07, 8'h0b, 8'h5a, 8'h5a, 0);
      tbl[4]  = mk(1, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 8'ha0, 8'hb0, 0);
      tbl[5]  = mk(1, 0, 8'h02, 8'h00, 1, 0, 8'h03, 8'h00, 8'hc0, 8'hd0, 0);
      tbl[6]  = mk(1, 0, 8'h04, 8'h00, 1, 0, 8'h05, 8'h00, 8'he0, 8'hf0, 0);
      tbl[7]  = mk(1, 0, 8'h06, 8'h00, 1, 0, 8'h07, 8'h00, 8'h0a, 8'h0b, 0);
      tbl[8]  = mk(1, 1, 8'h08, 8'h11, 0, 0, 8'h00, 8'h00, 8'h5a, 8'h0b, 0);
      tbl[9]  = mk(1, 1, 8'h08, 8'h22, 1, 0, 8'h08, 8'h00, 8'h11, 8'h11, 0);
      tbl[10] = mk(1, 1, 8'h09, 8'h33, 1, 1, 8'h09, 8'h44, 8'h5a, 8'h5a, 1);
      tbl[11] = mk(1, 0, 8'h09, 8'h00, 1, 0, 8'h08, 8'h00, 8'h33, 8'h22, 0);
      tbl[12] = mk(1, 0, 8'hff, 8'h00, 0, 0, 8'h00, 8'h00, 8'h5a, 8'h22, 0);

      clr = 1'b0; idle(); addra = 8'h00; addrb = 8'h00; dina = 8'h00; dinb = 8'h00;
      m_reset(0);
      m_reset(1);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      count_ready(n);
      chk("init_clear_len", n, 256);

      @(negedge clk); #1;
      drive(tbl[0]);
      for (int i = 0; i < 13; i++) begin
         @(negedge clk); #1;
         chk($sformatf("tbl%0d_douta", i), int'(da[0]), int'(tbl[i].exp_a));
         chk($sformatf("tbl%0d_doutb", i), int'(db[0]), int'(tbl[i].exp_b));
         chk($sformatf("tbl%0d_coll", i), int'(col[0]), int'(tbl[i].exp_col));
         if (i < 12) drive(tbl[i + 1]);
         else        idle();
      end

      // Out-of-range accesses on the 200-word build.
      @(negedge clk); #1;
      ena = 1'b1; wea = 1'b1; addra = 8'd250; dina = 8'h77; enb = 1'b0;
      @(negedge clk); #1;
      chk("oor_wr_err1", int'(err[1]), 1);
      chk("oor_wr_err0", int'(err[0]), 0);
      wea = 1'b0;
      @(negedge clk); #1;
      chk("oor_rd_err1", int'(err[1]), 1);
      addra = 8'd199;
      @(negedge clk); #1;
      chk("oor_rd_zero1", int'(da[1]), 0);
      chk("in_rng_err1", int'(err[1]), 0);
      idle();
      @(negedge clk); #1;
      chk("last_word_kept1", int'(da[1]), 8'h5a);

      // Random traffic with occasional clear requests and one reset.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         ena   = ($urandom_range(0, 3) != 0);
         enb   = ($urandom_range(0, 3) != 0);
         wea   = 1'($urandom_range(0, 1));
         web   = 1'($urandom_range(0, 1));
         addra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         addrb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         dina  = 8'($urandom);
         dinb  = 8'($urandom);
         clr   = ($urandom_range(0, 399) == 0);
         if (i == 1500) begin
            clr = 1'b0;
            reset_pulse();
         end
      end
      clr = 1'b0;
      idle();
      count_ready(n);
      chk("rand_ready", int'(rdy[0]), 1);

      // Clear requested during streaming writes.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         ena = 1'b1; wea = 1'b1; addra = 8'(i * 40); dina = 8'($urandom);
      end
      @(negedge clk); #1;
      clr = 1'b1;
      count_ready(n);
      chk("clr_clear_len", n, 257);
      #1 idle();
      for (int i = 0; i < 3; i++) begin
         ena = 1'b1; wea = 1'b0; addra = (i == 0) ? 8'd0 : (i == 1) ? 8'd128 : 8'd255;
         @(negedge clk); #1;
         chk($sformatf("post_clr_rd%0d", i), int'(da[0]), 8'h5a);
      end
      idle();

      // Reset in the middle of a clear.
      clr = 1'b1;
      @(negedge clk); #1;
      clr = 1'b0;
      repeat (50) @(negedge clk);
      reset_pulse();

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
